cassette_rec: RTL
=================

Name: cassette_rec

Overview:
- Cassette recorder: the write-side counterpart of the tape playback path.
- Watches the 6-bit sound DAC output while the cassette motor relay is on and demodulates CoCo FSK (1200 Hz cycle = 0, 2400 Hz cycle = 1).
- Aligns to the 0x55 leader and assembles bytes LSB first.
- Writes the resulting .CAS byte stream into the 64 KB cassette SRAM through a single-cycle write strobe.

Parameters:
- CLKS_PER_US, 57, system clocks per 1 µs timebase tick (57.27 MHz clk_sys).
- MID, 32, DAC midpoint code.
- HYST, 4, comparator hysteresis in DAC codes.
- MIN_US, 200, full periods shorter than this are glitches.
- THRESH_US, 625, period < THRESH_US decodes as bit 1; otherwise bit 0.
- MAX_US, 1500, period at or above this is a gap (loss of carrier).

Ports:
- clk  in  1  system clock (clk_sys)
- reset_n  in  1  asynchronous active-low reset
- en  in  1  cassette motor relay (cas_relay); recording active while high
- clear  in  1  synchronous; returns address to 0, clears full, forces IDLE
- dac_in  in  6  unsigned DAC sample (cocosound)
- wr  out  1  one-cycle SRAM write strobe
- wr_addr  out  16  SRAM byte address for the current write
- wr_data  out  8  byte to write
- full  out  1  address space exhausted; writes suppressed
- synced  out  1  high in state SYNC
- glitch  out  1  one-cycle pulse on a rejected short period

Behaviour:
- Reset values: wr=0, wr_addr=0, wr_data=0, full=0, synced=0, glitch=0. State IDLE, shift register 0, comparator low.
- Timebase: prescaler 0..CLKS_PER_US-1 issues a tick on wrap. The period counter (11 bits) increments per tick and saturates at 2047.
- Comparator cmp (registered):
  - goes high when dac_in >= MID+HYST;
  - goes low when dac_in <= MID-HYST;
  - otherwise holds.
  - rise = cmp & ~cmp_prev.
- On rise, the period counter resets to 0. The first rise after entering HUNT or IDLE→HUNT only arms measurement (first_edge flag) and decodes nothing.
- Period classification on each armed rise, p = counter value:
  - p < MIN_US: pulse glitch for one cycle; drop the bit; do not reset the counter (the edge is treated as noise).
  - MIN_US <= p < THRESH_US: bit 1.
  - THRESH_US <= p < MAX_US: bit 0.
  - p >= MAX_US: gap.
- Bit shift: new bit enters shift[7] and shift shifts right (LSB first).
- States:
  - IDLE: en=0. Comparator and counter keep running; no decode. en rising → HUNT with first_edge set.
  - HUNT: shift every decoded bit. When the shifted value equals 0x55, go to SYNC, set bitcnt=0, and write 0x55 (the aligning leader byte is recorded).
  - SYNC: bitcnt increments per decoded bit. When bitcnt wraps 7→0, write shift. Gap (classified on rise, or counter reaching MAX_US without an edge) → HUNT with first_edge set; a partial byte is discarded.
  - en=0 in any state → IDLE at the next clock; a partial byte is discarded; wr_addr is retained, so a restarted motor appends.
- Write timing:
  - The decoding rise is registered at cycle N.
  - wr=1 at N+1, with wr_data = assembled byte and wr_addr = current address.
  - wr_addr increments at N+2.
  - wr is never high on two consecutive cycles.
- Full: a write at wr_addr=0xFFFF is performed, full is set, and wr_addr stays 0xFFFF. While full=1, wr is suppressed; decoding continues.
- clear has priority over all events in the same cycle: address 0, full 0, state IDLE, and a pending wr is cancelled. If en is high, HUNT is entered on the following cycle.
- Simultaneous: a gap timeout and a rise in the same cycle are handled as a rise with p >= MAX_US (gap).
- reset_n assertion mid-byte: everything returns to reset values immediately; no write is emitted.

Decomposition:
- Package cassette_pkg holds:
  - the state enum (IDLE, HUNT, SYNC);
  - the SYNC_BYTE=8'h55 constant;
  - the period-counter width constant PER_W=11.
- Sub-module cas_fsk_demod covers the prescaler, hysteresis comparator, period counter and classifier. Its outputs are bit_valid, bit_val, gap and glitch.
- The top level holds the framing FSM and the address/write logic.

Test Plan:
- en=1; square wave of 1200/2400 Hz cycles carrying 16×0x55 then 0x3C, 0x01 → 18 writes at addr 0..17: 0x55×16, 0x3C, 0x01. synced rises on the first write.
- Stream starting on an odd bit (single leading 2400 Hz cycle) then 0x55 leader → first write is 0x55; no 0xAA is ever written.
- 100 µs spike cycle inserted mid-byte → glitch pulses once; byte values are unchanged.
- Carrier stops for 2 ms mid-byte → synced drops at the 1500 µs timeout, no partial write occurs, and a following 0x55 leader resyncs and appends at the next address.
- Preload address 0xFFFE via a stream of 65534 bytes (or force in the bench), then send 3 bytes → writes at 0xFFFE and 0xFFFF; full=1; third byte not written; wr_addr holds 0xFFFF.
- en drops mid-byte, then returns; clear pulsed while wr pending → no write after clear; wr_addr=0, full=0, state HUNT one cycle after clear.

Source files
------------

// File: rtl/cassette_pkg.sv
// cassette_pkg: shared types and constants for the cassette recorder.
//   casState_e : framing FSM states (IDLE, HUNT, SYNC)
//   SYNC_BYTE  : leader byte that establishes byte alignment
//   PER_W      : width of the microsecond period counter
package cassette_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HUNT,
        SYNC
    } casState_e;

    localparam logic [7:0] SYNC_BYTE = 8'h55;
    localparam int         PER_W     = 11;

endpackage

// File: rtl/cassette_rec_if.sv
// cassette_rec_if: control, audio input and SRAM write-port bundle of the
// cassette recorder.
//   en, clear, dac_in           : motor relay, synchronous clear, DAC sample
//   wr, wr_addr, wr_data, full  : single-cycle SRAM write port and full flag
//   synced, glitch              : framing status and rejected-edge pulse
// master drives the controls (system side), slave is the recorder itself.
interface cassette_rec_if;

    logic        en;
    logic        clear;
    logic [5:0]  dac_in;
    logic        wr;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        full;
    logic        synced;
    logic        glitch;

    modport master (
        output en, clear, dac_in,
        input  wr, wr_addr, wr_data, full, synced, glitch
    );

    modport slave (
        input  en, clear, dac_in,
        output wr, wr_addr, wr_data, full, synced, glitch
    );

endinterface

// File: rtl/cas_fsk_demod.sv
// cas_fsk_demod: FSK bit recovery from the sound DAC.
//   clk, reset_n : system clock, asynchronous active-low reset
//   dac_in       : unsigned 6-bit DAC sample
//   rearm        : next rising edge only starts a measurement
//   bit_valid    : one-cycle strobe, bit_val holds the decoded bit
//   gap          : carrier lost (long period or timeout)
//   glitch       : rising edge rejected as too short
module cas_fsk_demod
    import cassette_pkg::*;
#(
    parameter int CLKS_PER_US = 57,
    parameter int MID         = 32,
    parameter int HYST        = 4,
    parameter int MIN_US      = 200,
    parameter int THRESH_US   = 625,
    parameter int MAX_US      = 1500
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] dac_in,
    input  logic       rearm,
    output logic       bit_valid,
    output logic       bit_val,
    output logic       gap,
    output logic       glitch
);

    localparam int               PRE_W     = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(CLKS_PER_US - 1);
    localparam logic [5:0]       CMP_HI    = 6'(MID + HYST);
    localparam logic [5:0]       CMP_LO    = 6'(MID - HYST);
    localparam logic [PER_W-1:0] MIN_P     = PER_W'(MIN_US);
    localparam logic [PER_W-1:0] THRESH_P  = PER_W'(THRESH_US);
    localparam logic [PER_W-1:0] MAX_P     = PER_W'(MAX_US);
    localparam logic [PER_W-1:0] TIMEOUT_P = PER_W'(MAX_US - 1);
    localparam logic [PER_W-1:0] PER_SAT   = '1;

    logic [PRE_W-1:0] preQ;
    logic [PER_W-1:0] perQ;
    logic             cmpQ;
    logic             cmpPrevQ;
    logic             firstEdgeQ;

    logic tick;
    logic rise;
    logic armed;
    logic timeout;
    logic shortP;
    logic longP;

    assign tick    = (preQ == PRE_LAST);
    assign rise    = cmpQ & ~cmpPrevQ;
    // A rearm request in the same cycle as a rise makes that rise the arming edge.
    assign armed   = ~(firstEdgeQ | rearm);
    // Fires once, on the tick that carries the counter up to MAX_US.
    assign timeout = tick & (perQ == TIMEOUT_P);
    assign shortP  = (perQ < MIN_P);
    assign longP   = (perQ >= MAX_P) | timeout;

    assign glitch    = rise & armed & shortP;
    assign gap       = timeout | (rise & armed & longP);
    assign bit_valid = rise & armed & ~shortP & ~longP;
    assign bit_val   = (perQ < THRESH_P);

    // Timebase, hysteresis comparator and period measurement. A rejected short
    // edge leaves the counter alone so the next real edge still sees the full
    // period measured from the last accepted edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            preQ       <= '0;
            perQ       <= '0;
            cmpQ       <= 1'b0;
            cmpPrevQ   <= 1'b0;
            firstEdgeQ <= 1'b1;
        end else begin
            preQ <= tick ? '0 : preQ + PRE_W'(1);

            if (dac_in >= CMP_HI) begin
                cmpQ <= 1'b1;
            end else if (dac_in <= CMP_LO) begin
                cmpQ <= 1'b0;
            end
            cmpPrevQ <= cmpQ;

            if (rise && !glitch) begin
                perQ <= '0;
            end else if (tick && perQ != PER_SAT) begin
                perQ <= perQ + PER_W'(1);
            end

            if (rise) begin
                firstEdgeQ <= 1'b0;
            end else if (rearm) begin
                firstEdgeQ <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cassette_rec.sv
// cassette_rec: records the CoCo cassette FSK stream into the .CAS SRAM.
//   clk, reset_n : system clock, asynchronous active-low reset
//   bus (slave)  : en/clear/dac_in in; wr/wr_addr/wr_data/full/synced/glitch out
// Bits arrive LSB first; a 0x55 leader byte establishes byte alignment and is
// itself recorded. Writes are single-cycle strobes, the address advancing the
// cycle after each strobe and sticking at 0xFFFF once the SRAM is full.
module cassette_rec
    import cassette_pkg::*;
#(
    parameter int CLKS_PER_US = 57,
    parameter int MID         = 32,
    parameter int HYST        = 4,
    parameter int MIN_US      = 200,
    parameter int THRESH_US   = 625,
    parameter int MAX_US      = 1500
) (
    input  logic           clk,
    input  logic           reset_n,
    cassette_rec_if.slave  bus
);

    casState_e   stateQ;
    logic [7:0]  shiftQ;
    logic [2:0]  bitCntQ;
    logic [15:0] addrQ;
    logic        fullQ;
    logic        wrQ;
    logic [7:0]  wrDataQ;
    logic        syncedQ;
    logic        glitchQ;
    logic        rearmQ;

    logic       bitValid;
    logic       bitVal;
    logic       gap;
    logic       demodGlitch;
    logic [7:0] shiftNext;

    cas_fsk_demod #(
        .CLKS_PER_US (CLKS_PER_US),
        .MID         (MID),
        .HYST        (HYST),
        .MIN_US      (MIN_US),
        .THRESH_US   (THRESH_US),
        .MAX_US      (MAX_US)
    ) u_demod (
        .clk       (clk),
        .reset_n   (reset_n),
        .dac_in    (bus.dac_in),
        .rearm     (rearmQ),
        .bit_valid (bitValid),
        .bit_val   (bitVal),
        .gap       (gap),
        .glitch    (demodGlitch)
    );

    assign shiftNext = {bitVal, shiftQ[7:1]};

    // Framing FSM with address/write logic. Entering HUNT clears the shift
    // register and rearms the demodulator, so alignment always starts from a
    // fresh run of edges. clear outranks every other event in its cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stateQ  <= IDLE;
            shiftQ  <= '0;
            bitCntQ <= '0;
            addrQ   <= '0;
            fullQ   <= 1'b0;
            wrQ     <= 1'b0;
            wrDataQ <= '0;
            syncedQ <= 1'b0;
            glitchQ <= 1'b0;
            rearmQ  <= 1'b0;
        end else begin
            wrQ     <= 1'b0;
            rearmQ  <= 1'b0;
            glitchQ <= demodGlitch;

            if (bus.clear) begin
                stateQ  <= IDLE;
                addrQ   <= '0;
                fullQ   <= 1'b0;
                syncedQ <= 1'b0;
                bitCntQ <= '0;
            end else begin
                if (wrQ) begin
                    if (addrQ == 16'hFFFF) begin
                        fullQ <= 1'b1;
                    end else begin
                        addrQ <= addrQ + 16'd1;
                    end
                end

                if (!bus.en) begin
                    stateQ  <= IDLE;
                    syncedQ <= 1'b0;
                    bitCntQ <= '0;
                end else begin
                    case (stateQ)
                        IDLE: begin
                            stateQ <= HUNT;
                            rearmQ <= 1'b1;
                            shiftQ <= '0;
                        end
                        HUNT: begin
                            if (gap) begin
                                rearmQ <= 1'b1;
                                shiftQ <= '0;
                            end else if (bitValid) begin
                                shiftQ <= shiftNext;
                                if (shiftNext == SYNC_BYTE) begin
                                    stateQ  <= SYNC;
                                    syncedQ <= 1'b1;
                                    bitCntQ <= '0;
                                    if (!fullQ) begin
                                        wrQ     <= 1'b1;
                                        wrDataQ <= shiftNext;
                                    end
                                end
                            end
                        end
                        SYNC: begin
                            if (gap) begin
                                stateQ  <= HUNT;
                                syncedQ <= 1'b0;
                                rearmQ  <= 1'b1;
                                shiftQ  <= '0;
                                bitCntQ <= '0;
                            end else if (bitValid) begin
                                shiftQ  <= shiftNext;
                                bitCntQ <= bitCntQ + 3'd1;
                                if (bitCntQ == 3'd7 && !fullQ) begin
                                    wrQ     <= 1'b1;
                                    wrDataQ <= shiftNext;
                                end
                            end
                        end
                        default: stateQ <= IDLE;
                    endcase
                end
            end
        end
    end

    assign bus.wr      = wrQ;
    assign bus.wr_addr = addrQ;
    assign bus.wr_data = wrDataQ;
    assign bus.full    = fullQ;
    assign bus.synced  = syncedQ;
    assign bus.glitch  = glitchQ;

endmodule
